// File: rtl/mem_bus_arbiter_if.sv
// Two-master memory bus bundle: request/response lines for ports 0 and 1 plus the shared memory lines.
// The slave modport is the arbiter's view; master is the view of the cpu/loader/memory side.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic [DW-1:0] m0_rdata;
   logic          m0_ack;
   logic          m0_err;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [DW-1:0] m1_rdata;
   logic          m1_ack;
   logic          m1_err;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_rdata, mem_ready,
      output m0_rdata, m0_ack, m0_err,
      output m1_rdata, m1_ack, m1_err,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_rdata, mem_ready,
      input  m0_rdata, m0_ack, m0_err,
      input  m1_rdata, m1_ack, m1_err,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving two masters one-at-a-time access to a single memory bus,
// with a per-access timeout so a stalled memory returns an error instead of hanging the requester.
//
//  state  | meaning
//  IDLE   | no access; arbitrate between pending requests
//  ACCESS | memory access driven from latched request; wait for mem_ready or timeout
//  RESP   | one-cycle ack (and err) to the owner; update round-robin pointer
module mem_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clock,
   input  logic                reset,
   mem_bus_arbiter_if.slave    bus,
   output logic                owner,
   output logic                busy
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state_q;
   logic          owner_q;
   logic          last_owner_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          mem_en_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] m0_rdata_q;
   logic [DW-1:0] m1_rdata_q;
   logic          m0_ack_q;
   logic          m1_ack_q;
   logic          m0_err_q;
   logic          m1_err_q;
   logic          grant_d;

   // Tie goes to the port that did not own the bus last; otherwise the lone requester wins.
   assign grant_d = (bus.m0_req && bus.m1_req) ? ~last_owner_q : bus.m1_req;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_en_q     <= 1'b0;
         cnt_q        <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.m0_req || bus.m1_req) begin
                  owner_q  <= grant_d;
                  we_q     <= grant_d ? bus.m1_we    : bus.m0_we;
                  addr_q   <= grant_d ? bus.m1_addr  : bus.m0_addr;
                  wdata_q  <= grant_d ? bus.m1_wdata : bus.m0_wdata;
                  cnt_q    <= TO_LOAD;
                  mem_en_q <= 1'b1;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               if (bus.mem_ready) begin
                  mem_en_q <= 1'b0;
                  state_q  <= RESP;
                  if (owner_q) begin
                     m1_ack_q <= 1'b1;
                     if (!we_q) m1_rdata_q <= bus.mem_rdata;
                  end else begin
                     m0_ack_q <= 1'b1;
                     if (!we_q) m0_rdata_q <= bus.mem_rdata;
                  end
               end else if (cnt_q == '0) begin
                  // Timed out: abort with error; reads return zero.
                  mem_en_q <= 1'b0;
                  state_q  <= RESP;
                  if (owner_q) begin
                     m1_ack_q <= 1'b1;
                     m1_err_q <= 1'b1;
                     if (!we_q) m1_rdata_q <= '0;
                  end else begin
                     m0_ack_q <= 1'b1;
                     m0_err_q <= 1'b1;
                     if (!we_q) m0_rdata_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            RESP: begin
               last_owner_q <= owner_q;
               state_q      <= IDLE;
            end
            default: begin
               mem_en_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_en_q & we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.m0_rdata  = m0_rdata_q;
   assign bus.m0_ack    = m0_ack_q;
   assign bus.m0_err    = m0_err_q;
   assign bus.m1_rdata  = m1_rdata_q;
   assign bus.m1_ack    = m1_ack_q;
   assign bus.m1_err    = m1_err_q;
   assign owner         = owner_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: latency, fairness, latched address, timeout, async reset.
module tb_mem_bus_arbiter;
   logic clock;
   logic reset;
   logic owner;
   logic busy;
   int   n_tests;
   int   n_fail;

   mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .owner (owner),
      .busy  (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ready = 0;
      #1 reset = 1'b0;
      #1;
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_busy",   busy, 0);
      chk("rst_owner",  owner, 0);
      chk("rst_m0_ack", bus.m0_ack, 0);
      chk("rst_m1_ack", bus.m1_ack, 0);
      chk("rst_m0_rdata", bus.m0_rdata, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      step();
      reset = 1'b1;

      // T1: zero-wait read on port 0
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10;
      bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
      step();
      chk("t1_mem_en",   bus.mem_en, 1);
      chk("t1_mem_addr", bus.mem_addr, 32'h10);
      chk("t1_mem_we",   bus.mem_we, 0);
      chk("t1_busy",     busy, 1);
      chk("t1_early_ack", bus.m0_ack, 0);
      step();
      chk("t1_ack",    bus.m0_ack, 1);
      chk("t1_rdata",  bus.m0_rdata, 32'hDEADBEEF);
      chk("t1_err",    bus.m0_err, 0);
      chk("t1_en_off", bus.mem_en, 0);
      bus.m0_req = 0;
      step();
      chk("t1_ack_one_cycle", bus.m0_ack, 0);
      chk("t1_idle", busy, 0);

      // T2: both request after reset, expect grants 0,1,0
      reset = 1'b0;
      #2 reset = 1'b1;
      bus.m0_addr = 32'h100; bus.m1_addr = 32'h200; bus.m1_we = 0;
      bus.m0_req = 1; bus.m1_req = 1;
      for (int k = 0; k < 3; k++) begin
         logic        exp_own;
         logic [31:0] exp_addr;
         logic [31:0] d;
         exp_own  = (k == 1);
         exp_addr = exp_own ? 32'h200 : 32'h100;
         d        = 32'hA000_0000 + k;
         bus.mem_rdata = d;
         step();
         chk($sformatf("t2_owner_%0d", k), owner, exp_own);
         chk($sformatf("t2_addr_%0d", k), bus.mem_addr, exp_addr);
         step();
         chk($sformatf("t2_m0_ack_%0d", k), bus.m0_ack, !exp_own);
         chk($sformatf("t2_m1_ack_%0d", k), bus.m1_ack, exp_own);
         if (exp_own) chk("t2_m1_rdata", bus.m1_rdata, d);
         else         chk($sformatf("t2_m0_rdata_%0d", k), bus.m0_rdata, d);
         if (k == 2) begin
            bus.m0_req = 0; bus.m1_req = 0;
         end
         step();
      end
      bus.mem_ready = 0;

      // T3: port 1 write with 3 wait cycles, address changes mid-access
      bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h1234;
      step();
      chk("t3_addr",  bus.mem_addr, 32'h20);
      chk("t3_we",    bus.mem_we, 1);
      chk("t3_wdata", bus.mem_wdata, 32'h1234);
      chk("t3_owner", owner, 1);
      bus.m1_addr = 32'h99; bus.m1_wdata = 32'h5678;
      step(); step(); step();
      chk("t3_addr_held",  bus.mem_addr, 32'h20);
      chk("t3_wdata_held", bus.mem_wdata, 32'h1234);
      chk("t3_no_ack_yet", bus.m1_ack, 0);
      bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF_FFFF;
      step();
      chk("t3_ack",   bus.m1_ack, 1);
      chk("t3_err",   bus.m1_err, 0);
      chk("t3_rdata_kept", bus.m1_rdata, 32'hA000_0001);
      bus.m1_req = 0; bus.m1_we = 0; bus.mem_ready = 0;
      step();

      // T4: timeout on port 0 read, then a normal access
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h40;
      for (int i = 0; i < 16; i++) step();
      chk("t4_no_ack_16", bus.m0_ack, 0);
      chk("t4_en_16", bus.mem_en, 1);
      step();
      chk("t4_ack",   bus.m0_ack, 1);
      chk("t4_err",   bus.m0_err, 1);
      chk("t4_rdata", bus.m0_rdata, 0);
      bus.m0_req = 0;
      step();
      chk("t4_err_clear", bus.m0_err, 0);
      bus.m0_req = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h5555AAAA;
      step(); step();
      chk("t4_next_ack",   bus.m0_ack, 1);
      chk("t4_next_err",   bus.m0_err, 0);
      chk("t4_next_rdata", bus.m0_rdata, 32'h5555AAAA);
      bus.m0_req = 0; bus.mem_ready = 0;
      step();

      // T6: ready arrives on the threshold cycle
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h60;
      for (int i = 0; i < 16; i++) step();
      chk("t6_no_ack_16", bus.m1_ack, 0);
      bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
      step();
      chk("t6_ack",   bus.m1_ack, 1);
      chk("t6_err",   bus.m1_err, 0);
      chk("t6_rdata", bus.m1_rdata, 32'hCAFEF00D);
      bus.m1_req = 0; bus.mem_ready = 0;
      step();

      // T5: async reset mid-ACCESS, then tie goes to port 0
      bus.m1_req = 1; bus.m1_addr = 32'h70;
      step(); step();
      chk("t5_pre_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("t5_mem_en", bus.mem_en, 0);
      chk("t5_busy",   busy, 0);
      chk("t5_owner",  owner, 0);
      bus.m1_req = 0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t5_no_ack_%0d", i), bus.m1_ack | bus.m0_ack, 0);
      end
      bus.m0_req = 1; bus.m1_req = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_F00D;
      step();
      chk("t5_tie_owner", owner, 0);
      step();
      chk("t5_tie_ack", bus.m0_ack, 1);
      bus.m0_req = 0; bus.m1_req = 0; bus.mem_ready = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
